// File: rtl/timer_irq_bank_pkg.sv
// Shared definitions for the timer interrupt bank: register offsets,
// CTRL bit positions and the ID-register valid bit.
package timer_irq_pkg;

   localparam logic [3:0] TH_OFF   = 4'h0;
   localparam logic [3:0] TL_OFF   = 4'h4;
   localparam logic [3:0] CTRL_OFF = 4'h8;
   localparam int         CH_STRIDE = 16;

   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_IEN_BIT     = 1;
   localparam int CTRL_PEND_BIT    = 2;
   localparam int CTRL_ONESHOT_BIT = 3;

   localparam int ID_VALID_BIT = 31;

   function automatic logic [31:0] ctrl_word(input logic en, input logic ien,
                                             input logic pend, input logic oneshot);
      logic [31:0] w;
      w = 32'h0;
      w[CTRL_EN_BIT]      = en;
      w[CTRL_IEN_BIT]     = ien;
      w[CTRL_PEND_BIT]    = pend;
      w[CTRL_ONESHOT_BIT] = oneshot;
      return w;
   endfunction

endpackage

// File: rtl/timer_irq_bank_channel.sv
// One reload timer: TH reload value, TL up-counter and CTRL flags.
// Overflow reloads TL from TH and raises pending; a TL write cancels it.
module timer_channel
   import timer_irq_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we_th_i,
   input  logic             we_tl_i,
   input  logic             we_ctrl_i,
   input  logic [31:0]      wdata_i,
   output logic [CNT_W-1:0] th_o,
   output logic [CNT_W-1:0] tl_o,
   output logic             en_o,
   output logic             ien_o,
   output logic             pending_o,
   output logic             oneshot_o
);

   logic [CNT_W-1:0] th_q, th_d, tl_q, tl_d;
   logic             en_q, en_d, ien_q, ien_d, pend_q, pend_d, os_q, os_d;
   logic             ovf_s;
   logic             unused_s;

   assign unused_s = ^wdata_i;
   assign ovf_s    = en_q && (tl_q == {CNT_W{1'b1}}) && !we_tl_i;

   // Next-state: bus writes take priority over counting, except pending set beats W1C.
   always_comb begin
      th_d   = th_q;
      tl_d   = tl_q;
      en_d   = en_q;
      ien_d  = ien_q;
      pend_d = pend_q;
      os_d   = os_q;
      if (we_th_i) th_d = wdata_i[CNT_W-1:0];
      else         th_d = th_q;
      if (we_tl_i)    tl_d = wdata_i[CNT_W-1:0];
      else if (ovf_s) tl_d = th_q;
      else if (en_q)  tl_d = tl_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else            tl_d = tl_q;
      if (we_ctrl_i) begin
         en_d  = wdata_i[CTRL_EN_BIT];
         ien_d = wdata_i[CTRL_IEN_BIT];
         os_d  = wdata_i[CTRL_ONESHOT_BIT];
      end else if (ovf_s && os_q) begin
         en_d = 1'b0;
      end else begin
         en_d = en_q;
      end
      if (ovf_s)                                      pend_d = 1'b1;
      else if (we_ctrl_i && wdata_i[CTRL_PEND_BIT])   pend_d = 1'b0;
      else                                            pend_d = pend_q;
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q   <= {CNT_W{1'b0}};
         tl_q   <= {CNT_W{1'b0}};
         en_q   <= 1'b0;
         ien_q  <= 1'b0;
         pend_q <= 1'b0;
         os_q   <= 1'b0;
      end else begin
         th_q   <= th_d;
         tl_q   <= tl_d;
         en_q   <= en_d;
         ien_q  <= ien_d;
         pend_q <= pend_d;
         os_q   <= os_d;
      end
   end

   assign th_o      = th_q;
   assign tl_o      = tl_q;
   assign en_o      = en_q;
   assign ien_o     = ien_q;
   assign pending_o = pend_q;
   assign oneshot_o = os_q;

endmodule

// File: rtl/timer_irq_bank.sv
// Memory-mapped bank of reload timers with a lowest-index-first
// interrupt aggregator; reads are combinational from the registers.
module timer_irq_bank
   import timer_irq_pkg::*;
#(
   parameter int          NUM_CH    = 4,
   parameter int          CNT_W     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq_out,
   output logic [2:0]  irq_id
);

   localparam logic [29:0] STATUS_WOFF = 30'(NUM_CH * (CH_STRIDE / 4));
   localparam logic [29:0] ID_WOFF     = 30'(NUM_CH * (CH_STRIDE / 4) + 1);

   logic [29:0]      woff_s;
   logic [27:0]      ch_idx_s;
   logic [3:0]       reg_off_s;
   logic             in_ch_s;
   logic [CNT_W-1:0] th_s [NUM_CH];
   logic [CNT_W-1:0] tl_s [NUM_CH];
   logic [31:0]      rd_word_s [NUM_CH];
   logic [NUM_CH-1:0] en_s, ien_s, pend_s, os_s, active_s;
   logic [31:0]      ch_word_s, status_s, id_s;
   logic             unused_s;

   function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
      logic [31:0] r;
      r = 32'h0;
      r[CNT_W-1:0] = v;
      return r;
   endfunction

   // Addresses below the base wrap to large offsets and so decode as unmapped.
   assign woff_s    = addr[31:2] - BASE_ADDR[31:2];
   assign ch_idx_s  = woff_s[29:2];
   assign reg_off_s = {woff_s[1:0], 2'b00};
   assign in_ch_s   = (woff_s < STATUS_WOFF);
   assign unused_s  = ^addr[1:0];

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      logic sel_s;
      assign sel_s = in_ch_s && (ch_idx_s == 28'(n));

      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .clk       (clk),
         .reset     (reset),
         .we_th_i   (wr && sel_s && (reg_off_s == TH_OFF)),
         .we_tl_i   (wr && sel_s && (reg_off_s == TL_OFF)),
         .we_ctrl_i (wr && sel_s && (reg_off_s == CTRL_OFF)),
         .wdata_i   (wdata),
         .th_o      (th_s[n]),
         .tl_o      (tl_s[n]),
         .en_o      (en_s[n]),
         .ien_o     (ien_s[n]),
         .pending_o (pend_s[n]),
         .oneshot_o (os_s[n])
      );

      // Per-channel read word, zero unless this channel is addressed.
      always_comb begin
         rd_word_s[n] = 32'h0;
         if (sel_s) begin
            case (reg_off_s)
               TH_OFF:   rd_word_s[n] = zext(th_s[n]);
               TL_OFF:   rd_word_s[n] = zext(tl_s[n]);
               CTRL_OFF: rd_word_s[n] = ctrl_word(en_s[n], ien_s[n], pend_s[n], os_s[n]);
               default:  rd_word_s[n] = 32'h0;
            endcase
         end else begin
            rd_word_s[n] = 32'h0;
         end
      end
   end

   assign active_s = pend_s & ien_s;
   assign irq_out  = |active_s;

   // Lowest-numbered active channel wins the interrupt ID.
   always_comb begin
      irq_id = 3'd0;
      for (int n = NUM_CH - 1; n >= 0; n--) begin
         if (active_s[n]) irq_id = 3'(n);
         else             irq_id = irq_id;
      end
   end

   // STATUS/ID formation and the bus read mux.
   always_comb begin
      ch_word_s = 32'h0;
      for (int n = 0; n < NUM_CH; n++) ch_word_s = ch_word_s | rd_word_s[n];
      status_s = 32'h0;
      status_s[NUM_CH-1:0] = active_s;
      id_s = 32'h0;
      id_s[ID_VALID_BIT] = irq_out;
      id_s[2:0] = irq_id;
      if (!rd)                        rdata = 32'h0;
      else if (in_ch_s)               rdata = ch_word_s;
      else if (woff_s == STATUS_WOFF) rdata = status_s;
      else if (woff_s == ID_WOFF)     rdata = id_s;
      else                            rdata = 32'h0;
   end

endmodule

// File: doc/timer_irq_bank.md
# timer_irq_bank

Memory-mapped bank of `NUM_CH` independent reload timers with an interrupt aggregator. It replaces the single fixed timer in the CPU's peripheral space. It sits on the same `rd`/`wr`/`addr`/`wdata`/`rdata` data-memory bus as the data memory and peripheral block. Its single `irq_out` feeds the CPU's IRQ input, which the CPU masks while PC[31]=1. Per-channel mode, interrupt enable and a priority-encoded interrupt ID extend the old single-channel timer.

## Interface
- `NUM_CH`, 4, number of timer channels, 1..8
- `CNT_W`, 32, counter/reload width, 8..32; registers read zero-extended to 32 bits
- `BASE_ADDR`, 32'h4000_0100, word-aligned base of the bank
- `reset`  in  1  asynchronous, active-low
- `clk`  in  1  CPU clock; all state changes on rising edge
- `rd`  in  1  bus read strobe
- `wr`  in  1  bus write strobe
- `addr`  in  32  byte address; bits [1:0] ignored
- `wdata`  in  32  write data
- `rdata`  out  32  read data, combinational
- `irq_out`  out  1  OR over channels of (pending & ien)
- `irq_id`  out  3  index of lowest-numbered active channel; 0 when none

## Operation
- Channel n registers sit at BASE_ADDR + 16·n:
  - +0 TH: reload value
  - +4 TL: counter
  - +8 CTRL: [0] en, [1] ien, [2] pending (W1C), [3] oneshot; other bits read 0
- Global registers:
  - BASE_ADDR + 16·NUM_CH = STATUS: bit n = pending_n & ien_n
  - next word = ID: [31] valid, [2:0] irq_id
- Counting:
  - With en=1, TL increments by 1 every cycle.
  - When TL = all ones (CNT_W bits), the next edge loads TL←TH and sets pending.
  - If oneshot=1, that same edge also clears en.
  - With en=0, TL holds.
- Writes:
  - A write to TH, TL or CTRL takes effect at the edge where wr=1 and the address matches.
  - CTRL write sets en, ien and oneshot from wdata[0], [1] and [3].
  - wdata[2]=1 clears pending; 0 leaves it.
  - STATUS and ID are read-only; writes are ignored.
- Reads:
  - rdata = selected register when rd=1 and address mapped; otherwise 0.
  - Unmapped addresses: reads return 0, writes have no effect.
- Simultaneous events:
  - CPU write to TL in the overflow cycle: write wins; pending is not set, no reload.
  - W1C of pending in the overflow cycle: set wins; pending stays 1.
  - CTRL write clearing en in the overflow cycle: reload and pending still occur.
  - rd and wr together: read returns pre-edge value; write applies at the edge.
- Reset, at any time including mid-count: TH=0, TL=0, CTRL=0 for all channels; rdata=0 (rd low), irq_out=0, irq_id=0.

## Timing
- Read latency: 0 cycles, combinational from registers and address.
- Write latency: visible to a read in the cycle after the write edge.
- Overflow to irq_out:
  - TL = all ones in cycle k.
  - pending is set at the edge ending cycle k; irq_out=1 from cycle k+1.
- irq_out and irq_id are pure functions of registers; glitch-free relative to clk.
- Reload period with en held: 2^CNT_W − TH cycles between successive pending sets.
- irq_out drops in the cycle after the W1C write edge, unless another channel is active or a simultaneous set occurred.

## Structure
- Shared package `timer_irq_pkg` holds:
  - register offsets TH_OFF=0, TL_OFF=4, CTRL_OFF=8, CH_STRIDE=16
  - CTRL bit positions
  - the ID valid-bit position
- Sub-module `timer_channel`, instantiated NUM_CH times:
  - holds TH/TL/CTRL
  - inputs: per-channel write-select, wdata, reset, clk
  - outputs: register values and pending
- Top level holds address decode, read mux, STATUS/ID formation, and the lowest-index priority encoder.

## Test plan
- Reset mid-count: ch0 TH=5, en=1, assert reset low for 1 cycle → all registers read 0, irq_out=0.
- Periodic reload (CNT_W=32):
  - ch1 TH=32'hFFFF_FFF0, TL=32'hFFFF_FFF0, CTRL=4'b0011 → pending sets every 16 cycles.
  - irq_out=1 the cycle after TL=32'hFFFF_FFFF; TL reads 32'hFFFF_FFF0 after reload.
- One-shot: ch2 CTRL=4'b1011, TL=32'hFFFF_FFFE → after 2 edges pending=1, en=0; TL then holds TH.
- Priority:
  - ch3 and ch1 pending with ien=1 → irq_id=1, ID reads 32'h8000_0001.
  - W1C ch1 → irq_id=3 next cycle.
  - W1C ch3 → irq_out=0, ID=0.
- Collisions:
  - TL write of 0 in the overflow cycle → TL=0, pending stays 0.
  - W1C in the overflow cycle → pending remains 1.
- Bus decode: read BASE_ADDR+0x80 with NUM_CH=4 → 0; write there leaves all channels unchanged; rd=0 on a mapped address → rdata=0.
